// File: rtl/move_mailbox_slave.sv
`default_nettype none
// ============================================================================
//  Module   : move_mailbox_slave
//  Purpose  : Avalon-MM mailbox between HPS software and the chess move
//             engine: control/status, argument words, start/done handshake
//             and a move FIFO drained by POP reads.
//  Options  : define MAILBOX_IRQ_EN to enable the done/overflow interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module move_mailbox_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ARG_REGS   = 8,
  parameter int MOVE_WIDTH = 12,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          slave_address,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [DATA_WIDTH-1:0]          slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]        slave_byteenable,
  output logic [DATA_WIDTH-1:0]          slave_readdata,
  output logic [ARG_REGS*DATA_WIDTH-1:0] arg_data,
  output logic                           eng_start,
  input  logic                           eng_done,
  input  logic                           mv_valid,
  input  logic [MOVE_WIDTH-1:0]          mv_data,
  output logic                           mv_ready,
  output logic                           irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_CONTROL = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_STATUS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_POP     = ADDR_WIDTH'(2);
  localparam logic [CNT_W-1:0]      C_FULL_COUNT   = CNT_W'(FIFO_DEPTH);

  // Registered state
  logic                  start_q,     start_d;
  logic                  done_q,      done_d;
  logic                  busy_q,      busy_d;
  logic                  ovf_q,       ovf_d;
  logic                  irq_en_q,    irq_en_d;
  logic                  irq_q,       irq_d;
  logic                  eng_start_q, eng_start_d;
  logic                  ready_q,     ready_d;
  logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]      count_q,     count_d;
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic [DATA_WIDTH-1:0] arg_q [ARG_REGS];
  logic [DATA_WIDTH-1:0] arg_d [ARG_REGS];
  logic [MOVE_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Decoded strobes
  logic                  wr_ctrl_w, wr_status_w, soft_rst_w;
  logic                  full_w, push_w, pop_w;
  logic [DATA_WIDTH-1:0] ctrl_rd_w, status_rd_w, pop_rd_w;

  assign full_w      = (count_q == C_FULL_COUNT);
  // ready_q tracks !full one cycle later only across reset; otherwise it equals !full
  assign push_w      = mv_valid && ready_q;
  assign pop_w       = slave_read && (slave_address == C_ADDR_POP) && (count_q != '0);
  assign wr_ctrl_w   = slave_write && (slave_address == C_ADDR_CONTROL) && slave_byteenable[0];
  assign wr_status_w = slave_write && (slave_address == C_ADDR_STATUS);
  assign soft_rst_w  = wr_ctrl_w && slave_writedata[2];

  // Read-back views of the register file
  always_comb begin
    ctrl_rd_w    = '0;
    ctrl_rd_w[0] = start_q;
    ctrl_rd_w[1] = done_q;
    ctrl_rd_w[3] = irq_en_q;
    status_rd_w  = '0;
    status_rd_w[CNT_W-1:0] = count_q;
    status_rd_w[16] = (count_q == '0);
    status_rd_w[17] = full_w;
    status_rd_w[18] = ovf_q;
    status_rd_w[19] = busy_q;
    pop_rd_w = '0;
    if (count_q != '0) pop_rd_w[MOVE_WIDTH-1:0] = mem_q[rd_ptr_q];
  end

  // Next-state logic for handshake, FIFO bookkeeping, argument words and read data
  always_comb begin
    start_d     = start_q;
    done_d      = done_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    irq_en_d    = irq_en_q;
    eng_start_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    arg_d       = arg_q;

    // Engine completion only counts while a search is outstanding
    if (busy_q && eng_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    // CONTROL write: a start edge launches a search, start=0 acknowledges done
    if (wr_ctrl_w) begin
      if (slave_writedata[0] && !start_q) begin
        eng_start_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
      end
      if (!slave_writedata[0]) done_d = 1'b0;
      start_d = slave_writedata[0];
`ifdef MAILBOX_IRQ_EN
      irq_en_d = slave_writedata[3];
`endif
    end

    // Argument words with per-byte lane enables
    for (int i = 0; i < ARG_REGS; i++) begin
      if (slave_write && (slave_address == ADDR_WIDTH'(3 + i))) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (slave_byteenable[b]) arg_d[i][8*b +: 8] = slave_writedata[8*b +: 8];
        end
      end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Overflow is sticky; a new drop in the same cycle beats the clear
    if (wr_status_w && slave_writedata[18]) ovf_d = 1'b0;
    if (mv_valid && full_w) ovf_d = 1'b1;

    // Read data is captured only on a read and held until the next one
    if (slave_read) begin
      rdata_d = '0;
      if (slave_address == C_ADDR_CONTROL)     rdata_d = ctrl_rd_w;
      else if (slave_address == C_ADDR_STATUS) rdata_d = status_rd_w;
      else if (slave_address == C_ADDR_POP)    rdata_d = pop_rd_w;
      for (int i = 0; i < ARG_REGS; i++) begin
        if (slave_address == ADDR_WIDTH'(3 + i)) rdata_d = arg_q[i];
      end
    end

    // Soft reset wipes the search and the FIFO but keeps arguments and irq_en;
    // it overrides any eng_done, push or start edge in the same cycle
    if (soft_rst_w) begin
      start_d     = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
      ovf_d       = 1'b0;
      eng_start_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end

    ready_d = (count_d != C_FULL_COUNT);
`ifdef MAILBOX_IRQ_EN
    irq_d = irq_en_d && (done_d || ovf_d);
`else
    irq_d = 1'b0;
`endif
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      eng_start_q <= 1'b0;
      ready_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < ARG_REGS; i++) arg_q[i] <= '0;
    end else begin
      start_q     <= start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      eng_start_q <= eng_start_d;
      ready_q     <= ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      arg_q       <= arg_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_w && !soft_rst_w && !reset) mem_q[wr_ptr_q] <= mv_data;
  end

  generate
    for (genvar g = 0; g < ARG_REGS; g++) begin : g_arg_out
      assign arg_data[DATA_WIDTH*g +: DATA_WIDTH] = arg_q[g];
    end
  endgenerate

  assign slave_readdata = rdata_q;
  assign eng_start      = eng_start_q;
  assign mv_ready       = ready_q;
  assign irq            = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_move_mailbox_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_mailbox_slave
//  Purpose  : Directed self-checking bench for move_mailbox_slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_move_mailbox_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   slave_address;
  logic         slave_read;
  logic         slave_write;
  logic [31:0]  slave_writedata;
  logic [3:0]   slave_byteenable;
  logic [31:0]  slave_readdata;
  logic [255:0] arg_data;
  logic         eng_start;
  logic         eng_done;
  logic         mv_valid;
  logic [11:0]  mv_data;
  logic         mv_ready;
  logic         irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_mailbox_slave dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_byteenable (slave_byteenable),
    .slave_readdata   (slave_readdata),
    .arg_data         (arg_data),
    .eng_start        (eng_start),
    .eng_done         (eng_done),
    .mv_valid         (mv_valid),
    .mv_data          (mv_data),
    .mv_ready         (mv_ready),
    .irq              (irq)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled there too
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    slave_address = a; slave_writedata = d; slave_byteenable = be; slave_write = 1'b1;
    cycle();
    slave_write = 1'b0; slave_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    cycle();
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic push(input logic [11:0] m);
    mv_valid = 1'b1; mv_data = m;
    cycle();
    mv_valid = 1'b0;
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    cycle();
    eng_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++; if (slave_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", slave_readdata); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start got %b want 0", eng_start); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (arg_data !== 256'h0) begin errors++; $display("FAIL reset_arg_data got %h want 0", arg_data); end
    reset = 1'b0;
    cycle();
    checks++; if (mv_ready !== 1'b1) begin errors++; $display("FAIL reset_mv_ready got %b want 1", mv_ready); end
  endtask

  task automatic test_start();
    logic [31:0] d;
    bus_write(4'd0, 32'h1, 4'hF);
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL start_pulse_hi got %b want 1", eng_start); end
    cycle();
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL start_pulse_lo got %b want 0", eng_start); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0009_0000) begin errors++; $display("FAIL start_status_busy got %h want 00090000", d); end
    bus_write(4'd0, 32'h1, 4'hF);
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL start_no_repulse got %b want 0", eng_start); end
    pulse_done();
    bus_read(4'd0, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL start_done_ctrl got %h want 3", d); end
    bus_write(4'd0, 32'h0, 4'hF);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL start_clear_ctrl got %h want 0", d); end
    pulse_done();
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL start_idle_done got %h want 0", d); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    push(12'h0C1); push(12'h0C9); push(12'h0D2);
    bus_read(4'd1, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL fifo_count3 got %h want 3", d); end
    bus_read(4'd2, d);
    checks++; if (d !== 32'h0C1) begin errors++; $display("FAIL fifo_pop0 got %h want 0c1", d); end
    bus_read(4'd2, d);
    checks++; if (d !== 32'h0C9) begin errors++; $display("FAIL fifo_pop1 got %h want 0c9", d); end
    bus_read(4'd2, d);
    checks++; if (d !== 32'h0D2) begin errors++; $display("FAIL fifo_pop2 got %h want 0d2", d); end
    bus_read(4'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fifo_pop_empty got %h want 0", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL fifo_empty_status got %h want 00010000", d); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] d;
    for (int i = 0; i < 64; i++) push(12'(i) ^ 12'hA50);
    checks++; if (mv_ready !== 1'b0) begin errors++; $display("FAIL full_mv_ready got %b want 0", mv_ready); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0002_0040) begin errors++; $display("FAIL full_status got %h want 00020040", d); end
    push(12'hFFF);
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0006_0040) begin errors++; $display("FAIL overflow_status got %h want 00060040", d); end
    bus_write(4'd1, 32'h0004_0000, 4'hF);
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0002_0040) begin errors++; $display("FAIL overflow_clear got %h want 00020040", d); end
    for (int i = 0; i < 64; i++) begin
      bus_read(4'd2, d);
      checks++;
      if (d !== {20'h0, 12'(i) ^ 12'hA50}) begin errors++; $display("FAIL full_drain_%0d got %h want %h", i, d, 12'(i) ^ 12'hA50); end
    end
    checks++; if (mv_ready !== 1'b1) begin errors++; $display("FAIL drained_mv_ready got %b want 1", mv_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int nexp = 0;
    for (int i = 0; i < 5; i++) push(12'h100 + 12'(i));
    // 62 simultaneous push+pop cycles carry both pointers across the wrap
    for (int i = 5; i < 67; i++) begin
      mv_valid = 1'b1; mv_data = 12'h100 + 12'(i);
      slave_address = 4'd2; slave_read = 1'b1;
      cycle();
      mv_valid = 1'b0; slave_read = 1'b0;
      checks++;
      if (slave_readdata !== {20'h0, 12'h100 + 12'(nexp)}) begin
        errors++; $display("FAIL b2b_pop_%0d got %h want %h", nexp, slave_readdata, 12'h100 + 12'(nexp));
      end
      nexp++;
    end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL b2b_count got %h want 5", d); end
    for (int i = 0; i < 5; i++) begin
      bus_read(4'd2, d);
      checks++;
      if (d !== {20'h0, 12'h100 + 12'(nexp)}) begin errors++; $display("FAIL b2b_tail_%0d got %h want %h", nexp, d, 12'h100 + 12'(nexp)); end
      nexp++;
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d;
    bus_write(4'd3, 32'hDEAD_BEEF, 4'hF);
    bus_write(4'd4, 32'hFFFF_FFFF, 4'hF);
    bus_write(4'd4, 32'h0000_AB00, 4'b0010);
    bus_write(4'd10, 32'h1234_5678, 4'hF);
    bus_write(4'd11, 32'hCAFE_F00D, 4'hF);
    checks++; if (arg_data[63:32] !== 32'hFFFF_ABFF) begin errors++; $display("FAIL arg_byteenable got %h want ffffabff", arg_data[63:32]); end
    bus_read(4'd11, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
    for (int i = 0; i < 10; i++) push(12'h200 + 12'(i));
    bus_write(4'd0, 32'h1, 4'hF);
    eng_done = 1'b1;
    bus_write(4'd0, 32'h4, 4'hF);
    eng_done = 1'b0;
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL softrst_status got %h want 00010000", d); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL softrst_ctrl got %h want 0", d); end
    checks++; if (arg_data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL softrst_arg0 got %h want deadbeef", arg_data[31:0]); end
    checks++; if (arg_data[255:224] !== 32'h1234_5678) begin errors++; $display("FAIL softrst_arg7 got %h want 12345678", arg_data[255:224]); end
    bus_read(4'd4, d);
    checks++; if (d !== 32'hFFFF_ABFF) begin errors++; $display("FAIL softrst_arg1_read got %h want ffffabff", d); end
    pulse_done();
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL softrst_late_done got %h want 0", d); end
  endtask

  task automatic test_reset_mid_search();
    logic [31:0] d;
    bus_write(4'd0, 32'h1, 4'hF);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    pulse_done();
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl got %h want 0", d); end
    checks++; if (arg_data !== 256'h0) begin errors++; $display("FAIL midreset_args got %h want 0", arg_data); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
`ifdef MAILBOX_IRQ_EN
    bus_write(4'd0, 32'h8, 4'hF);
    bus_write(4'd0, 32'h9, 4'hF);
    pulse_done();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    bus_write(4'd0, 32'h8, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL irq_ctrl got %h want 8", d); end
`else
    bus_write(4'd0, 32'h9, 4'hF);
    pulse_done();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b want 0", irq); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL irq_en_ro got %h want 3", d); end
    bus_write(4'd0, 32'h0, 4'hF);
`endif
  endtask

  initial begin
    reset = 1'b1; slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = 32'h0; slave_byteenable = 4'h0;
    eng_done = 1'b0; mv_valid = 1'b0; mv_data = 12'h0;
    test_reset();
    test_start();
    test_fifo_order();
    test_full_overflow();
    test_back_to_back();
    test_soft_reset();
    test_reset_mid_search();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
